// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: redirect select codes, bubble encoding,
// fetch FSM and F/D register control encodings.
package core_pkg;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      REDIR
   } fetch_state_t;

   typedef enum logic [1:0] {
      FD_HOLD,
      FD_LOAD,
      FD_BUBBLE,
      FD_FLUSH
   } fd_ctrl_t;

   // Redirect targets are halfword aligned; bit 0 is always dropped.
   function automatic logic [31:0] align_target(input logic [31:0] target);
      return {target[31:1], 1'b0};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == '1) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// 64-bit F/D pipeline register {pc, insn}: hold, load, bubble (pc loads,
// insn becomes the bubble) and flush (pc holds, insn becomes the bubble).
module fd_pipe_reg
   import core_pkg::*;
#(
   parameter logic [31:0] BUBBLE_INSN = core_pkg::NOP_INSN
) (
   input  logic        clock,
   input  logic        reset,
   input  fd_ctrl_t    ctrl,
   input  logic [31:0] pc_in,
   input  logic [31:0] insn_in,
   output logic [31:0] pc_out,
   output logic [31:0] insn_out
);

   logic [63:0] fd_q;
   logic [63:0] fd_d;

   always_comb begin
      fd_d = fd_q;
      case (ctrl)
         FD_LOAD:   fd_d = {pc_in, insn_in};
         FD_BUBBLE: fd_d = {pc_in, BUBBLE_INSN};
         FD_FLUSH:  fd_d = {fd_q[63:32], BUBBLE_INSN};
         default:   fd_d = fd_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fd_q <= {32'h0000_0000, BUBBLE_INSN};
      end else begin
         fd_q <= fd_d;
      end
   end

   assign pc_out   = fd_q[63:32];
   assign insn_out = fd_q[31:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC mux, boot/redirect FSM and F/D register.
// Optional FETCH_STATS_EN adds saturating redirect and stall counters.
module fetch_pc_unit
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0100_0000,
   parameter logic [31:0] NOP_INSN = core_pkg::NOP_INSN
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  PC_sel,
   input  logic [31:0] ret_pc,
   input  logic        stall,
   input  logic [31:0] imem_insn,
   output logic [31:0] pc_f,
   output logic [31:0] pc_d,
   output logic [31:0] insn_d,
   output logic        squash_x,
   output logic        misalign_err
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] branch_redirects,
   output logic [31:0] jump_redirects,
   output logic [31:0] stall_cycles
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_f_q, pc_f_d;
   logic         misalign_q, misalign_d;
   fd_ctrl_t     fd_ctrl;

   logic active;
   logic take_branch;
   logic take_jump;
   logic redirect;
   logic hold;

   // Branch overrides stall; a stalled jump waits because its operand is stale.
   assign active      = (state_q != BOOT);
   assign take_branch = active && (PC_sel == PC_SEL_BRANCH);
   assign take_jump   = active && (PC_sel == PC_SEL_JUMP) && !stall;
   assign redirect    = take_branch || take_jump;
   assign hold        = active && stall && !take_branch;

   always_comb begin
      state_d    = state_q;
      pc_f_d     = pc_f_q;
      misalign_d = misalign_q;
      fd_ctrl    = FD_HOLD;
      case (state_q)
         BOOT: begin
            fd_ctrl = FD_FLUSH;
            state_d = RUN;
         end
         RUN, REDIR: begin
            if (redirect) begin
               pc_f_d     = align_target(ret_pc);
               fd_ctrl    = FD_BUBBLE;
               misalign_d = misalign_q | ret_pc[1];
               state_d    = REDIR;
            end else if (hold) begin
               fd_ctrl = FD_HOLD;
               state_d = RUN;
            end else begin
               pc_f_d  = pc_f_q + 32'd4;
               fd_ctrl = FD_LOAD;
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_f_q     <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_f_q     <= pc_f_d;
         misalign_q <= misalign_d;
      end
   end

   fd_pipe_reg #(
      .BUBBLE_INSN (NOP_INSN)
   ) u_fd_pipe_reg (
      .clock    (clock),
      .reset    (reset),
      .ctrl     (fd_ctrl),
      .pc_in    (pc_f_q),
      .insn_in  (imem_insn),
      .pc_out   (pc_d),
      .insn_out (insn_d)
   );

   assign pc_f         = pc_f_q;
   assign squash_x     = !reset && take_branch;
   assign misalign_err = misalign_q;

`ifdef FETCH_STATS_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] jump_cnt_q, jump_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      jump_cnt_d   = jump_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (take_branch) begin
         branch_cnt_d = sat_inc(branch_cnt_q);
      end
      if (take_jump) begin
         jump_cnt_d = sat_inc(jump_cnt_q);
      end
      if (hold) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         branch_cnt_q <= '0;
         jump_cnt_q   <= '0;
         stall_cnt_q  <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         jump_cnt_q   <= jump_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign branch_redirects = branch_cnt_q;
   assign jump_redirects   = jump_cnt_q;
   assign stall_cycles     = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver queues hand-computed
// expectations per cycle, a monitor pops and compares them.
module tb_fetch_pc_unit;
   import core_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  PC_sel = 2'b00;
   logic [31:0] ret_pc = '0;
   logic        stall = 1'b0;
   logic [31:0] imem_insn = '0;
   logic [31:0] pc_f;
   logic [31:0] pc_d;
   logic [31:0] insn_d;
   logic        squash_x;
   logic        misalign_err;
`ifdef FETCH_STATS_EN
   logic [31:0] branch_redirects;
   logic [31:0] jump_redirects;
   logic [31:0] stall_cycles;
`endif

   fetch_pc_unit #(
      .RESET_PC (32'h0100_0000),
      .NOP_INSN (32'h0000_0013)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .PC_sel       (PC_sel),
      .ret_pc       (ret_pc),
      .stall        (stall),
      .imem_insn    (imem_insn),
      .pc_f         (pc_f),
      .pc_d         (pc_d),
      .insn_d       (insn_d),
      .squash_x     (squash_x),
      .misalign_err (misalign_err)
`ifdef FETCH_STATS_EN
      ,
      .branch_redirects (branch_redirects),
      .jump_redirects   (jump_redirects),
      .stall_cycles     (stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] pc_f;
      logic [31:0] pc_d;
      logic        chk_pcd;
      logic [31:0] insn;
      logic        sq;
      logic        mis;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic mon_busy = 1'b0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; expectations describe squash_x in
   // that cycle and the registered outputs after the following rising edge.
   task automatic step(input string nm, input logic rst, input logic [1:0] sel,
                       input logic [31:0] ret, input logic stl, input logic [31:0] insn,
                       input logic [31:0] e_pcf, input logic [31:0] e_pcd, input logic e_chk_pcd,
                       input logic [31:0] e_insn, input logic e_sq, input logic e_mis);
      exp_t e;
      @(negedge clock);
      reset     = rst;
      PC_sel    = sel;
      ret_pc    = ret;
      stall     = stl;
      imem_insn = insn;
      e.name    = nm;
      e.pc_f    = e_pcf;
      e.pc_d    = e_pcd;
      e.chk_pcd = e_chk_pcd;
      e.insn    = e_insn;
      e.sq      = e_sq;
      e.mis     = e_mis;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      logic sq_seen;
      forever begin
         @(negedge clock);
         #1;
         if (q.size() > 0) begin
            mon_busy = 1'b1;
            e = q.pop_front();
            sq_seen = squash_x;
            @(posedge clock);
            #1;
            chk({e.name, ".squash_x"}, {31'b0, sq_seen}, {31'b0, e.sq});
            chk({e.name, ".pc_f"}, pc_f, e.pc_f);
            if (e.chk_pcd) chk({e.name, ".pc_d"}, pc_d, e.pc_d);
            chk({e.name, ".insn_d"}, insn_d, e.insn);
            chk({e.name, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, e.mis});
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : driver
      int budget;
      //    name       rst sel    ret_pc         stl insn            pc_f           pc_d           chk  insn_d         sq  mis
      step("rst",      1, 2'b10, 32'h0100_0443, 0, 32'h0000_0093, 32'h0100_0000, 32'h0000_0000, 1, NOP,           0, 0);
      step("boot",     0, 2'b10, 32'h0100_0443, 0, 32'h0000_0093, 32'h0100_0000, 32'h0000_0000, 1, NOP,           0, 0);
      step("first",    0, 2'b00, 32'h0,         0, 32'h0000_0093, 32'h0100_0004, 32'h0100_0000, 1, 32'h0000_0093, 0, 0);
      step("seq",      0, 2'b00, 32'h0,         0, 32'h0010_0113, 32'h0100_0008, 32'h0100_0004, 1, 32'h0010_0113, 0, 0);
      step("jump",     0, 2'b01, 32'h0100_0040, 0, 32'h0020_0193, 32'h0100_0040, 32'h0,         0, NOP,           0, 0);
      step("jtgt",     0, 2'b00, 32'h0,         0, 32'h0030_0213, 32'h0100_0044, 32'h0100_0040, 1, 32'h0030_0213, 0, 0);
      step("br_stall", 0, 2'b10, 32'h0100_0020, 1, 32'hDEAD_BEEF, 32'h0100_0020, 32'h0100_0044, 1, NOP,           1, 0);
      step("btgt",     0, 2'b00, 32'h0,         0, 32'h0040_0293, 32'h0100_0024, 32'h0100_0020, 1, 32'h0040_0293, 0, 0);
      step("jst1",     0, 2'b01, 32'h0100_0080, 1, 32'h0050_0313, 32'h0100_0024, 32'h0100_0020, 1, 32'h0040_0293, 0, 0);
      step("jst2",     0, 2'b01, 32'h0100_0080, 1, 32'h0050_0313, 32'h0100_0024, 32'h0100_0020, 1, 32'h0040_0293, 0, 0);
      step("jrel",     0, 2'b01, 32'h0100_0080, 0, 32'h0050_0313, 32'h0100_0080, 32'h0,         0, NOP,           0, 0);
      step("b2b_1",    0, 2'b10, 32'h0100_0100, 0, 32'h0, 32'h0100_0100, 32'h0100_0080, 1, NOP,                  1, 0);
      step("b2b_2",    0, 2'b10, 32'h0100_0200, 0, 32'h0, 32'h0100_0200, 32'h0100_0100, 1, NOP,                  1, 0);
      step("misal",    0, 2'b10, 32'h0100_0033, 0, 32'h0, 32'h0100_0032, 32'h0100_0200, 1, NOP,                  1, 1);
      step("sticky",   0, 2'b00, 32'h0,         0, 32'h0060_0393, 32'h0100_0036, 32'h0100_0032, 1, 32'h0060_0393, 0, 1);
      step("rst_mid",  1, 2'b10, 32'h0100_0500, 0, 32'h0, 32'h0100_0000, 32'h0000_0000, 1, NOP,                  0, 0);
      step("boot2",    0, 2'b00, 32'h0,         0, 32'h0070_0013, 32'h0100_0000, 32'h0000_0000, 1, NOP,           0, 0);
      step("j_top",    0, 2'b01, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,         0, NOP,           0, 0);
      step("wrap",     0, 2'b00, 32'h0,         0, 32'h0070_0413, 32'h0000_0000, 32'hFFFF_FFFC, 1, 32'h0070_0413, 0, 0);
      step("sel11",    0, 2'b11, 32'h0100_0777, 0, 32'h0080_0493, 32'h0000_0004, 32'h0000_0000, 1, 32'h0080_0493, 0, 0);
      step("br_a",     0, 2'b10, 32'h0000_0100, 0, 32'h0, 32'h0000_0100, 32'h0000_0004, 1, NOP,                  1, 0);
      step("br_b",     0, 2'b10, 32'h0000_0200, 0, 32'h0, 32'h0000_0200, 32'h0000_0100, 1, NOP,                  1, 0);
      step("br_c",     0, 2'b10, 32'h0000_0300, 0, 32'h0, 32'h0000_0300, 32'h0000_0200, 1, NOP,                  1, 0);
      step("tail",     0, 2'b00, 32'h0,         0, NOP,           32'h0000_0304, 32'h0000_0300, 1, NOP,           0, 0);

      budget = 0;
      while ((q.size() > 0 || mon_busy) && budget < 50) begin
         @(posedge clock);
         #2;
         budget++;
      end
      if (q.size() > 0 || mon_busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

`ifdef FETCH_STATS_EN
      chk("branch_redirects", branch_redirects, 32'd3);
      chk("jump_redirects", jump_redirects, 32'd1);
      chk("stall_cycles", stall_cycles, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
